// File: rtl/buffered_transmitter.sv
// buffered_transmitter: serial link transmitter with a small input FIFO.
// Frame on S_Data, one bit per cycle: start 1, DATA_W data bits LSB first,
// optional even-parity bit, stop 0. The line idles at 0.
// Optional feature: define BUFFERED_TX_PARITY_EN to add the parity bit.
module buffered_transmitter #(
  parameter int unsigned DATA_W = 55,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              Clk_S,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] TX_Data,
  input  logic              TX_Data_Valid,
  output logic              TX_Ready,
  output logic              S_Data,
  output logic              Busy,
  output logic [7:0]        Frame_Cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef BUFFERED_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP
  } state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              push, pop, frame_done, line_d, fifo_nonempty, last_bit;

`ifdef BUFFERED_TX_PARITY_EN
  logic              parity_q;
`endif

  assign push          = TX_Data_Valid & TX_Ready;
  assign fifo_nonempty = (count_q != '0);
  assign last_bit      = (bit_cnt == BIT_W'(DATA_W - 1));

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state, pop decision and next line level.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    line_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          state_d = ST_START;
          pop     = 1'b1;
        end
      end
      ST_START: state_d = ST_DATA;
      ST_DATA: begin
        if (last_bit) begin
`ifdef BUFFERED_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef BUFFERED_TX_PARITY_EN
      ST_PARITY: state_d = ST_STOP;
`endif
      ST_STOP: begin
        frame_done = 1'b1;
        if (fifo_nonempty) begin
          state_d = ST_START;
          pop     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: line_d = 1'b1;
      ST_DATA:  line_d = shreg[0];
`ifdef BUFFERED_TX_PARITY_EN
      ST_PARITY: line_d = parity_q;
`endif
      default:  line_d = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge Clk_S) begin
    if (push) mem[wr_ptr] <= TX_Data;
  end

  // FIFO pointers, occupancy and the ready flag for the next edge.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      TX_Ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q  <= count_d;
      TX_Ready <= (count_d < CNT_W'(DEPTH));
    end
  end

  // Shift register loads on pop and shifts right on every cycle spent in DATA.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (pop)                    shreg <= mem[rd_ptr];
      else if (state_d == ST_DATA) shreg <= shreg >> 1;
      if (state_q == ST_DATA && state_d == ST_DATA) bit_cnt <= bit_cnt + BIT_W'(1);
      else                                          bit_cnt <= '0;
    end
  end

`ifdef BUFFERED_TX_PARITY_EN
  // Even parity of the word being sent, captured when it leaves the FIFO.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n)   parity_q <= 1'b0;
    else if (pop) parity_q <= ^mem[rd_ptr];
  end
`endif

  // Registered line, busy flag and completed-frame counter.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      S_Data    <= 1'b0;
      Busy      <= 1'b0;
      Frame_Cnt <= 8'd0;
    end else begin
      S_Data <= line_d;
      Busy   <= (state_d != ST_IDLE) || (count_d != '0);
      if (frame_done) Frame_Cnt <= Frame_Cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_buffered_transmitter.sv
// Testbench for buffered_transmitter: directed and random traffic checked
// cycle by cycle against a frame-level model (word queue + frame bit vector).
module tb_buffered_transmitter;

  localparam int DATA_W = 55;
  localparam int DEPTH  = 2;
`ifdef BUFFERED_TX_PARITY_EN
  localparam int FLEN = DATA_W + 3;
`else
  localparam int FLEN = DATA_W + 2;
`endif

  logic              Clk_S = 1'b0;
  logic              Rst_n = 1'b1;
  logic [DATA_W-1:0] TX_Data = '0;
  logic              TX_Data_Valid = 1'b0;
  logic              TX_Ready;
  logic              S_Data;
  logic              Busy;
  logic [7:0]        Frame_Cnt;

  buffered_transmitter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clk_S         (Clk_S),
    .Rst_n         (Rst_n),
    .TX_Data       (TX_Data),
    .TX_Data_Valid (TX_Data_Valid),
    .TX_Ready      (TX_Ready),
    .S_Data        (S_Data),
    .Busy          (Busy),
    .Frame_Cnt     (Frame_Cnt)
  );

  always #5 Clk_S = ~Clk_S;

  // Reference model state.
  logic [DATA_W-1:0] q[$];
  logic [FLEN-1:0]   cur;
  int                pos = -1;
  int                fcnt = 0;
  bit                ready_m = 1'b1;
  bit                last_push = 1'b0;
  bit                wrapped = 1'b0;

  int total = 0;
  int bad   = 0;

  function automatic logic [FLEN-1:0] make_frame(input logic [DATA_W-1:0] w);
    logic [FLEN-1:0] f;
    f    = '0;
    f[0] = 1'b1;
    for (int i = 0; i < DATA_W; i++) f[1+i] = w[i];
`ifdef BUFFERED_TX_PARITY_EN
    f[DATA_W+1] = ^w;
`endif
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  task automatic model_reset();
    q.delete();
    pos     = -1;
    fcnt    = 0;
    ready_m = 1'b1;
  endtask

  task automatic model_edge(input logic v, input logic [DATA_W-1:0] d);
    bit acc;
    acc = v && ready_m;
    if (pos >= 0) begin
      if (pos == FLEN - 1) begin
        pos  = -1;
        fcnt = (fcnt + 1) % 256;
        if (fcnt == 0) wrapped = 1'b1;
      end else begin
        pos++;
      end
    end
    if (pos < 0 && q.size() > 0) begin
      cur = make_frame(q.pop_front());
      pos = 0;
    end
    if (acc) q.push_back(d);
    ready_m   = (q.size() < DEPTH);
    last_push = acc;
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_s;
    logic exp_busy;
    exp_s    = (pos >= 0) ? cur[pos] : 1'b0;
    exp_busy = (pos >= 0) || (q.size() > 0);
    check_val("s_data",    8'(S_Data),   8'(exp_s));
    check_val("tx_ready",  8'(TX_Ready), 8'(ready_m));
    check_val("busy",      8'(Busy),     8'(exp_busy));
    check_val("frame_cnt", Frame_Cnt,    8'(fcnt));
  endtask

  task automatic step(input logic v, input logic [DATA_W-1:0] d);
    TX_Data_Valid = v;
    TX_Data       = d;
    @(posedge Clk_S);
    model_edge(v, d);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted between edges, held for n edges.
  task automatic reset_cycles(input int n);
    Rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < n; i++) begin
      @(posedge Clk_S);
      #1;
      check_outputs();
    end
    Rst_n = 1'b1;
  endtask

  // Hold a word on the input until it is accepted.
  task automatic offer(input logic [DATA_W-1:0] w);
    int n;
    n = 0;
    last_push = 1'b0;
    while (!last_push && n < 400) begin
      step(1'b1, w);
      n++;
    end
    total++;
    assert (last_push) else begin
      bad++;
      $error("FAIL offer_timeout word=%0h cycles=%0d", w, n);
    end
  endtask

  // Run idle until the model has nothing left to send.
  task automatic drain();
    int n;
    n = 0;
    while ((pos >= 0 || q.size() > 0) && n < 1000) begin
      step(1'b0, rand_word());
      n++;
    end
    step(1'b0, rand_word());
    check_val("drain_busy", 8'(Busy), 8'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] pat;
    int n;
    pat = 55'b000_101101110_1110001110_101101110_1110001110_101101110_11101;

    // Reset held with valid asserted: nothing accepted, nothing sent.
    TX_Data_Valid = 1'b1;
    TX_Data       = rand_word();
    #2;
    reset_cycles(10);

    // First edge after release accepts; second word queued; reset mid-frame.
    step(1'b1, rand_word());
    step(1'b1, rand_word());
    for (int i = 0; i < 30; i++) step(1'b0, rand_word());
    reset_cycles(2);
    check_val("midreset_cnt", Frame_Cnt, 8'd0);
    for (int i = 0; i < 2 * FLEN; i++) step(1'b0, rand_word());

    // Single frames: 3 (parity 0) and 7 (parity 1).
    offer(55'd3);
    drain();
    check_val("cnt_after_3", Frame_Cnt, 8'd1);
    offer(55'd7);
    drain();
    check_val("cnt_after_7", Frame_Cnt, 8'd2);

    // Buffering: three words presented back to back.
    offer(rand_word());
    offer(rand_word());
    offer(rand_word());
    drain();
    check_val("cnt_after_abc", Frame_Cnt, 8'd5);

    // Alternating pattern word.
    offer(pat);
    drain();
    check_val("cnt_after_pat", Frame_Cnt, 8'd6);

    // Random traffic.
    for (int i = 0; i < 600; i++) step(($urandom % 3) != 0, rand_word());
    drain();

    // Continuous traffic until the frame counter wraps.
    n = 0;
    while (!(wrapped && fcnt >= 2) && n < 20000) begin
      step(1'b1, rand_word());
      n++;
    end
    total++;
    assert (wrapped) else begin
      bad++;
      $error("FAIL wrap_timeout cycles=%0d frames=%0d", n, fcnt);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
